// File: rtl/blockram_lsu.sv
// Load/store front end for a byte-lane block RAM: sub-word steering,
// sign/zero extension, two-beat misaligned accesses and range checking.
module blockram_lsu #(
  parameter int BYTE_WIDTH    = 8,
  parameter int BYTES         = 4,
  parameter int DATA_WIDTH    = BYTE_WIDTH * BYTES,
  parameter int DEPTH         = 50,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     rsp_err
);

  localparam int LB = $clog2(BYTES);
  localparam int IW = $clog2(DEPTH);
  localparam int W2 = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, BEAT2, RESP} state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDRESS_WIDTH-1:0] w;
  logic [LB-1:0]            o;
  logic [4:0]               n;
  logic                     span;
  logic                     err;
  logic                     accept;
  logic [15:0]              shamt;
  logic [W2-1:0]            sdata;
  logic [2*BYTES-1:0]       smask;

  assign w      = req_addr >> LB;
  assign o      = req_addr[LB-1:0];
  assign n      = 5'd1 << req_size;
  assign span   = (5'(o) + n) > 5'(BYTES);
  assign err    = (w >= ADDRESS_WIDTH'(DEPTH))
               || (span && w >= ADDRESS_WIDTH'(DEPTH - 1))
               || (req_size == 2'd3 && BYTES == 4);
  assign accept = req_valid && req_ready;
  assign shamt  = 16'(o) * 16'(BYTE_WIDTH);
  assign sdata  = W2'(req_wdata) << shamt;
  assign smask  = (2*BYTES)'(((16'd1 << n) - 16'd1) << o);

  logic                  l_we;
  logic                  l_uns;
  logic                  l_err;
  logic [1:0]            l_size;
  logic [LB-1:0]         l_off;
  logic [IW-1:0]         l_widx;
  logic [DATA_WIDTH-1:0] l_hdata;
  logic [BYTES-1:0]      l_hmask;
  logic [DATA_WIDTH-1:0] rd0;
  logic [DATA_WIDTH-1:0] rd1;

  always_ff @(posedge clk) begin
    if (accept) begin
      l_we    <= req_we;
      l_uns   <= req_unsigned;
      l_err   <= err;
      l_size  <= req_size;
      l_off   <= o;
      l_widx  <= w[IW-1:0];
      l_hdata <= sdata[W2-1:DATA_WIDTH];
      l_hmask <= smask[2*BYTES-1:BYTES];
    end
  end

  logic                  wr_en;
  logic                  rd0_en;
  logic                  rd1_en;
  logic [IW-1:0]         acc_idx;
  logic [BYTES-1:0]      wr_mask;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    state_nx = state;
    wr_en    = 1'b0;
    rd0_en   = 1'b0;
    rd1_en   = 1'b0;
    acc_idx  = w[IW-1:0];
    wr_mask  = smask[BYTES-1:0];
    wr_data  = sdata[DATA_WIDTH-1:0];
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (span && !err) ? BEAT2 : RESP;
          wr_en    = req_we && !err;
          rd0_en   = !req_we && !err;
        end
      end
      BEAT2: begin
        state_nx = RESP;
        acc_idx  = l_widx + IW'(1);
        wr_mask  = l_hmask;
        wr_data  = l_hdata;
        wr_en    = l_we;
        rd1_en   = !l_we;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Reset abandons any beat in flight, including its RAM write
    if (reset) begin
      wr_en  = 1'b0;
      rd0_en = 1'b0;
      rd1_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_mask[i])
          mem[acc_idx][i*BYTE_WIDTH +: BYTE_WIDTH] <=
            wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
    if (rd0_en) rd0 <= mem[acc_idx];
    if (rd1_en) rd1 <= mem[acc_idx];
  end

  logic [DATA_WIDTH-1:0] val;
  logic [DATA_WIDTH-1:0] keep;
  logic [DATA_WIDTH-1:0] ext;
  logic [4:0]            ln;
  logic                  sbit;

  always_comb begin
    ln   = 5'd1 << l_size;
    val  = DATA_WIDTH'({rd1, rd0} >> (16'(l_off) * 16'(BYTE_WIDTH)));
    keep = '0;
    sbit = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (5'(i) < ln) keep[i*BYTE_WIDTH +: BYTE_WIDTH] = '1;
      if (5'(i + 1) == ln) sbit = val[(i+1)*BYTE_WIDTH-1];
    end
    ext = (val & keep) | ((!l_uns && sbit) ? ~keep : '0);
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && l_err;
  assign rsp_rdata = (state == RESP && !l_err && !l_we) ? ext : '0;

endmodule
